// File: rtl/psx_pkg.sv
// rtl/psx_pkg.sv - shared constants, state type and command-byte helper for the PSX pad engine
package psx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } psx_state_e;

    localparam logic [7:0] PSX_START        = 8'h01;
    localparam logic [7:0] PSX_ID_DIGITAL   = 8'h41;
    localparam logic [7:0] PSX_ID_ANALOG    = 8'h73;
    localparam logic [3:0] PSX_LEN_DIGITAL  = 4'd5;
    localparam logic [3:0] PSX_LEN_ANALOG   = 4'd9;
    localparam logic [7:0] PSX_STICK_CENTER = 8'h80;
    localparam logic [3:0] PSX_BUF_DEPTH    = 4'd9;

    function automatic logic [7:0] psx_tx_byte(input logic [3:0] idx, input logic [7:0] cmd_poll);
        case (idx)
            4'd0:    return PSX_START;
            4'd1:    return cmd_poll;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/psx_edge_sync.sv
// rtl/psx_edge_sync.sv - dat synchronizer and c_clk rise/fall detector
module psx_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic c_clk,
    input  logic dat,
    output logic dat_sync,
    output logic c_rise,
    output logic c_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   c_prev_q, c_prev_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = dat;
        c_prev_d  = c_clk;
    end

    // c_prev resets high so an idle-high c_clk does not look like an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            c_prev_q <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            c_prev_q <= c_prev_d;
        end
    end

    assign dat_sync = sync_q[SYNC_STAGES-1];
    assign c_rise   = ~c_prev_q & c_clk;
    assign c_fall   = c_prev_q & ~c_clk;

endmodule

// File: rtl/psx_frame_engine.sv
// rtl/psx_frame_engine.sv - PSX pad frame engine: drives cmd, captures reply bytes, publishes pad state
module psx_frame_engine
    import psx_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_POLL    = 8'h42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_clk,
    input  logic [3:0]  c_counter,
    input  logic        ready,
    input  logic        err_f,
    input  logic        dat,
    output logic        cmd,
    output logic [3:0]  bytes_expected,
    output logic [15:0] buttons,
    output logic [7:0]  rjoy_x,
    output logic [7:0]  rjoy_y,
    output logic [7:0]  ljoy_x,
    output logic [7:0]  ljoy_y,
    output logic [7:0]  ctrl_id,
    output logic        analog_mode,
    output logic        frame_valid,
    output logic        frame_err
);

    logic dat_sync, c_rise, c_fall;

    psx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .c_clk    (c_clk),
        .dat      (dat),
        .dat_sync (dat_sync),
        .c_rise   (c_rise),
        .c_fall   (c_fall)
    );

    psx_state_e                          state_q, state_d;
    logic                                cmd_q, cmd_d;
    logic [2:0]                          bit_idx_q, bit_idx_d;
    logic [6:0]                          rx_q, rx_d;
    logic [PSX_BUF_DEPTH-1:0][7:0]       buf_q, buf_d;
    logic [3:0]                          cnt_prev_q, cnt_prev_d;
    logic                                id_pend_q, id_pend_d;
    logic [7:0]                          ctrl_id_q, ctrl_id_d;
    logic                                analog_q, analog_d;
    logic [3:0]                          bytes_exp_q, bytes_exp_d;
    logic [15:0]                         buttons_q, buttons_d;
    logic [7:0]                          rjoy_x_q, rjoy_x_d, rjoy_y_q, rjoy_y_d;
    logic [7:0]                          ljoy_x_q, ljoy_x_d, ljoy_y_q, ljoy_y_d;
    logic                                frame_valid_q, frame_valid_d;
    logic                                frame_err_q, frame_err_d;
    logic [7:0]                          rx_next;
    logic [7:0]                          tx_byte;

    always_comb begin
        rx_next       = {dat_sync, rx_q};
        tx_byte       = psx_tx_byte(c_counter, CMD_POLL);
        state_d       = state_q;
        cmd_d         = cmd_q;
        bit_idx_d     = bit_idx_q;
        rx_d          = rx_q;
        buf_d         = buf_q;
        cnt_prev_d    = c_counter;
        id_pend_d     = 1'b0;
        ctrl_id_d     = ctrl_id_q;
        analog_d      = analog_q;
        bytes_exp_d   = bytes_exp_q;
        buttons_d     = buttons_q;
        rjoy_x_d      = rjoy_x_q;
        rjoy_y_d      = rjoy_y_q;
        ljoy_x_d      = ljoy_x_q;
        ljoy_y_d      = ljoy_y_q;
        frame_valid_d = 1'b0;
        frame_err_d   = frame_err_q;

        // ID byte was stored last cycle; frame length follows it immediately
        if (id_pend_q) begin
            ctrl_id_d   = buf_q[1];
            analog_d    = (buf_q[1] == PSX_ID_ANALOG);
            bytes_exp_d = (buf_q[1] == PSX_ID_ANALOG) ? PSX_LEN_ANALOG : PSX_LEN_DIGITAL;
        end

        case (state_q)
            IDLE: begin
                cmd_d = 1'b1;
                if (c_fall) begin
                    state_d   = SHIFT;
                    bit_idx_d = 3'd0;
                    cmd_d     = tx_byte[0];
                end
            end
            SHIFT: begin
                if (c_counter != cnt_prev_q) begin
                    bit_idx_d = 3'd0;
                end else if (c_rise) begin
                    rx_d      = rx_next[7:1];
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7 && c_counter < PSX_BUF_DEPTH) begin
                        buf_d[c_counter] = rx_next;
                        id_pend_d        = (c_counter == 4'd1);
                    end
                end
                if (c_fall) begin
                    cmd_d = tx_byte[bit_idx_q];
                end
                if (ready) begin
                    state_d = DONE;
                    cmd_d   = 1'b1;
                    if (err_f) begin
                        frame_err_d = 1'b1;
                    end else begin
                        buttons_d     = ~{buf_q[4], buf_q[3]};
                        rjoy_x_d      = analog_q ? buf_q[5] : PSX_STICK_CENTER;
                        rjoy_y_d      = analog_q ? buf_q[6] : PSX_STICK_CENTER;
                        ljoy_x_d      = analog_q ? buf_q[7] : PSX_STICK_CENTER;
                        ljoy_y_d      = analog_q ? buf_q[8] : PSX_STICK_CENTER;
                        frame_valid_d = 1'b1;
                        frame_err_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cmd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cmd_q         <= 1'b1;
            bit_idx_q     <= 3'd0;
            rx_q          <= '0;
            buf_q         <= '0;
            cnt_prev_q    <= 4'd0;
            id_pend_q     <= 1'b0;
            ctrl_id_q     <= 8'h00;
            analog_q      <= 1'b0;
            bytes_exp_q   <= PSX_LEN_DIGITAL;
            buttons_q     <= 16'h0000;
            rjoy_x_q      <= PSX_STICK_CENTER;
            rjoy_y_q      <= PSX_STICK_CENTER;
            ljoy_x_q      <= PSX_STICK_CENTER;
            ljoy_y_q      <= PSX_STICK_CENTER;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            bit_idx_q     <= bit_idx_d;
            rx_q          <= rx_d;
            buf_q         <= buf_d;
            cnt_prev_q    <= cnt_prev_d;
            id_pend_q     <= id_pend_d;
            ctrl_id_q     <= ctrl_id_d;
            analog_q      <= analog_d;
            bytes_exp_q   <= bytes_exp_d;
            buttons_q     <= buttons_d;
            rjoy_x_q      <= rjoy_x_d;
            rjoy_y_q      <= rjoy_y_d;
            ljoy_x_q      <= ljoy_x_d;
            ljoy_y_q      <= ljoy_y_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign cmd            = cmd_q;
    assign bytes_expected = bytes_exp_q;
    assign buttons        = buttons_q;
    assign rjoy_x         = rjoy_x_q;
    assign rjoy_y         = rjoy_y_q;
    assign ljoy_x         = ljoy_x_q;
    assign ljoy_y         = ljoy_y_q;
    assign ctrl_id        = ctrl_id_q;
    assign analog_mode    = analog_q;
    assign frame_valid    = frame_valid_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_psx_frame_engine.sv
// tb/tb_psx_frame_engine.sv - scoreboard bench for psx_frame_engine
module tb_psx_frame_engine;
    import psx_pkg::*;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst, c_clk, ready, err_f, dat;
    logic [3:0]  c_counter;
    logic        cmd, analog_mode, frame_valid, frame_err;
    logic [3:0]  bytes_expected;
    logic [15:0] buttons;
    logic [7:0]  rjoy_x, rjoy_y, ljoy_x, ljoy_y, ctrl_id;

    always #5 clk = ~clk;

    psx_frame_engine #(.SYNC_STAGES(2), .CMD_POLL(8'h42)) dut (
        .clk            (clk),
        .rst            (rst),
        .c_clk          (c_clk),
        .c_counter      (c_counter),
        .ready          (ready),
        .err_f          (err_f),
        .dat            (dat),
        .cmd            (cmd),
        .bytes_expected (bytes_expected),
        .buttons        (buttons),
        .rjoy_x         (rjoy_x),
        .rjoy_y         (rjoy_y),
        .ljoy_x         (ljoy_x),
        .ljoy_y         (ljoy_y),
        .ctrl_id        (ctrl_id),
        .analog_mode    (analog_mode),
        .frame_valid    (frame_valid),
        .frame_err      (frame_err)
    );

    typedef struct packed {
        logic [15:0] buttons;
        logic [31:0] sticks;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_valid  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            exp_t e;
            n_valid++;
            check_eq("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("buttons", {16'd0, buttons}, {16'd0, e.buttons});
                check_eq("sticks", {rjoy_x, rjoy_y, ljoy_x, ljoy_y}, e.sticks);
                check_eq("frame_err_on_valid", {31'd0, frame_err}, 32'd0);
            end
        end
    end

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_cmd"}, {31'd0, cmd}, 32'd1);
        check_eq({pfx, "_bytes_expected"}, {28'd0, bytes_expected}, 32'd5);
        check_eq({pfx, "_buttons"}, {16'd0, buttons}, 32'd0);
        check_eq({pfx, "_sticks"}, {rjoy_x, rjoy_y, ljoy_x, ljoy_y}, 32'h80808080);
        check_eq({pfx, "_ctrl_id"}, {24'd0, ctrl_id}, 32'd0);
        check_eq({pfx, "_flags"}, {29'd0, analog_mode, frame_valid, frame_err}, 32'd0);
    endtask

    task automatic send_frame(input logic [8:0][7:0] rep, input int nbytes, input bit err,
                              input bit chk_cmd, input int abort_byte, input bit jump10);
        logic [7:0] early, late, exp_tx;
        logic [7:0] cur;
        bit         is_analog;
        exp_t       e;
        int         total;
        total = nbytes + (jump10 ? 1 : 0);
        is_analog = (rep[1] == PSX_ID_ANALOG);
        for (int k = 0; k < total; k++) begin
            c_counter = (k == nbytes) ? 4'd10 : k[3:0];
            cur = (k == nbytes) ? 8'h00 : rep[k];
            tick(2);
            early = '0;
            late  = '0;
            for (int b = 0; b < 8; b++) begin
                c_clk = 1'b0;
                dat   = cur[b];
                tick(1);
                early[b] = cmd;
                tick(HALF - 1);
                late[b] = cmd;
                if (k == abort_byte && b == 3) begin
                    rst   = 1'b0;
                    c_clk = 1'b1;
                    dat   = 1'b1;
                    tick(2);
                    check_reset("midreset");
                    rst = 1'b1;
                    tick(2);
                    return;
                end
                c_clk = 1'b1;
                tick(HALF);
            end
            if (chk_cmd && k < 3) begin
                exp_tx = psx_tx_byte(k[3:0], 8'h42);
                check_eq($sformatf("cmd_fall_b%0d", k), {24'd0, early}, {24'd0, exp_tx});
                check_eq($sformatf("cmd_rise_b%0d", k), {24'd0, late}, {24'd0, exp_tx});
            end
            if (k == 1) begin
                check_eq("ctrl_id", {24'd0, ctrl_id}, {24'd0, rep[1]});
                check_eq("bytes_expected", {28'd0, bytes_expected}, is_analog ? 32'd9 : 32'd5);
                check_eq("analog_mode", {31'd0, analog_mode}, {31'd0, is_analog});
            end
        end
        dat = 1'b1;
        tick(2);
        if (!err) begin
            e.buttons = ~{rep[4], rep[3]};
            e.sticks  = is_analog ? {rep[5], rep[6], rep[7], rep[8]} : 32'h80808080;
            sb_q.push_back(e);
        end
        ready = 1'b1;
        err_f = err;
        tick(1);
        ready = 1'b0;
        err_f = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick(1);
        check_eq("sb_drained", sb_q.size(), 32'd0);
        tick(2);
        check_eq("cmd_idle", {31'd0, cmd}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0][7:0] rep;
        int v0;
        rst = 1'b0; c_clk = 1'b1; dat = 1'b1; ready = 1'b0; err_f = 1'b0; c_counter = 4'd0;
        tick(3);
        check_reset("reset");
        rst = 1'b1;
        tick(2);

        rep = '0;
        rep[0] = 8'hFF; rep[1] = PSX_ID_DIGITAL; rep[2] = 8'h5A; rep[3] = 8'hFE; rep[4] = 8'hFF;
        v0 = n_valid;
        send_frame(rep, 5, 1'b0, 1'b1, -1, 1'b0);
        check_eq("digital_pulses", n_valid - v0, 32'd1);

        rep = '0;
        rep[0] = 8'hFF; rep[1] = PSX_ID_ANALOG; rep[2] = 8'h5A; rep[3] = 8'h7F; rep[4] = 8'hBF;
        rep[5] = 8'h10; rep[6] = 8'h20; rep[7] = 8'h30; rep[8] = 8'h40;
        send_frame(rep, 9, 1'b0, 1'b0, -1, 1'b0);
        check_eq("analog_rjoy_x", {24'd0, rjoy_x}, 32'h10);
        check_eq("analog_ljoy_y", {24'd0, ljoy_y}, 32'h40);

        rep = '0;
        rep[0] = 8'hFF; rep[1] = PSX_ID_DIGITAL; rep[2] = 8'h5A; rep[3] = 8'h00; rep[4] = 8'h00;
        v0 = n_valid;
        send_frame(rep, 5, 1'b1, 1'b0, -1, 1'b0);
        check_eq("err_frame_err", {31'd0, frame_err}, 32'd1);
        check_eq("err_no_valid", n_valid - v0, 32'd0);
        check_eq("err_buttons_held", {16'd0, buttons}, 32'h4080);

        rep[3] = 8'hFE; rep[4] = 8'hFF;
        send_frame(rep, 5, 1'b0, 1'b0, -1, 1'b0);
        check_eq("err_cleared", {31'd0, frame_err}, 32'd0);

        rep = '0;
        rep[0] = 8'hFF; rep[1] = PSX_ID_ANALOG; rep[2] = 8'h5A; rep[3] = 8'h5A; rep[4] = 8'hA5;
        rep[5] = 8'h01; rep[6] = 8'h02; rep[7] = 8'h03; rep[8] = 8'h04;
        v0 = n_valid;
        send_frame(rep, 9, 1'b0, 1'b0, 3, 1'b0);
        check_eq("abort_no_valid", n_valid - v0, 32'd0);
        send_frame(rep, 9, 1'b0, 1'b0, -1, 1'b0);
        check_eq("post_reset_buttons", {16'd0, buttons}, 32'h5AA5);

        rep = '0;
        rep[0] = 8'hFF; rep[1] = PSX_ID_DIGITAL; rep[2] = 8'h5A; rep[3] = 8'hFE; rep[4] = 8'hFF;
        send_frame(rep, 5, 1'b0, 1'b0, -1, 1'b1);
        check_eq("jump_no_x", {31'd0, $isunknown({buttons, rjoy_x, rjoy_y, ljoy_x, ljoy_y, ctrl_id, bytes_expected})}, 32'd0);
        check_eq("jump_ctrl_id", {24'd0, ctrl_id}, 32'h41);

        tick(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/psx_frame_engine.md
PSX_FRAME_ENGINE -- requirements
Module: psx_frame_engine

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops synchronizing dat.
REQ-002 SHALL have parameter CMD_POLL, default 8'h42: command byte sent at byte index 1.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port c_clk, input, 1: controller clock from the clock generator, idle high, synchronous to clk.
REQ-006 SHALL have port c_counter, input, 4: index of the byte currently transferred.
REQ-007 SHALL have port ready, input, 1: one-cycle pulse from the clock generator marking frame complete.
REQ-008 SHALL have port err_f, input, 1: clock generator's no-ack error flag for the current frame.
REQ-009 SHALL have port dat, input, 1: controller data line, asynchronous.
REQ-010 SHALL have port cmd, output, 1: controller command line, idle high.
REQ-011 SHALL have port bytes_expected, output, 4: frame length fed back to the clock generator.
REQ-012 SHALL have port buttons, output, 16: button state, 1 = pressed.
REQ-013 SHALL have ports rjoy_x, rjoy_y, ljoy_x, ljoy_y, output, 8 each: analog stick values.
REQ-014 SHALL have port ctrl_id, output, 8: last received ID byte.
REQ-015 SHALL have port analog_mode, output, 1: high when ctrl_id = 8'h73.
REQ-016 SHALL have port frame_valid, output, 1: one-cycle pulse when outputs are updated.
REQ-017 SHALL have port frame_err, output, 1: sticky error, cleared by the next good frame.

Function
REQ-018 SHALL detect c_clk edges by comparing c_clk with a one-cycle-delayed copy; falling edge = prev 1 and cur 0.
REQ-019 SHALL use states IDLE, SHIFT and DONE: IDLE->SHIFT on the first c_clk falling edge; SHIFT->DONE on ready; DONE->IDLE the following cycle.
REQ-020 SHALL transmit LSB first: on each falling edge, cmd = tx_byte[bit_idx]; tx_byte = 8'h01 at index 0, CMD_POLL at index 1, 8'h00 at all other indices.
REQ-021 SHALL shift synchronized dat into the rx register on each c_clk rising edge, LSB first, then increment bit_idx (3 bits, wraps 7->0).
REQ-022 SHALL write the rx byte into buffer entry c_counter on the eighth rising edge; a change of c_counter SHALL also reset bit_idx to 0.
REQ-023 SHALL ignore c_counter values of 9 or greater; no write and no wrap.
REQ-024 SHALL latch ctrl_id, when byte index 1 completes, one cycle after that byte's eighth rising edge.
REQ-025 SHALL set bytes_expected at the same time as ctrl_id: 9 if the ID is 8'h73, otherwise 5.
REQ-026 SHALL drive cmd high in IDLE and DONE.
REQ-027 SHALL update outputs in DONE when err_f = 0, one cycle after ready:
  - buttons = ~{byte4, byte3};
  - rjoy_x/rjoy_y/ljoy_x/ljoy_y = bytes 5..8 if analog_mode, else 8'h80;
  - frame_valid = 1 for one cycle;
  - frame_err = 0.
REQ-028 SHALL, in DONE when err_f = 1, set frame_err = 1, hold all data outputs, and keep frame_valid = 0.
REQ-029 SHALL give err_f priority when ready and err_f are high in the same cycle.
REQ-030 SHALL ignore c_clk edges in DONE.

Reset
REQ-031 SHALL set, while rst = 0:
  - state = IDLE, cmd = 1, bit_idx = 0;
  - bytes_expected = 5, buttons = 0, sticks = 8'h80;
  - ctrl_id = 0, analog_mode = 0, frame_valid = 0, frame_err = 0;
  - buffer and synchronizer cleared.
REQ-032 SHALL abort a frame on reset mid-frame; the first frame after release starts from IDLE with no partial data published.

Structure
REQ-033 SHALL take from shared package psx_pkg: state enum; PSX_START 8'h01; PSX_ID_DIGITAL 8'h41; PSX_ID_ANALOG 8'h73; PSX_LEN_DIGITAL 5; PSX_LEN_ANALOG 9; PSX_STICK_CENTER 8'h80.
REQ-034 SHALL implement the dat synchronizer plus c_clk edge detector as one sub-module, psx_edge_sync.

Verification
REQ-035 Digital pad: bench replies ID 8'h41, bytes 3/4 = 8'hFE/8'hFF -> bytes_expected stays 5; buttons = 16'h0001; sticks = 8'h80; one frame_valid pulse.
REQ-036 Analog pad: ID 8'h73, bytes 5..8 = 8'h10/20/30/40 -> bytes_expected = 9 after byte 1; analog_mode = 1; rjoy_x = 8'h10, ljoy_y = 8'h40.
REQ-037 cmd check: monitor cmd across bytes 0-2 -> bit streams 8'h01, 8'h42, 8'h00, LSB first, each bit stable from falling edge to rising edge.
REQ-038 Error: ready and err_f high in the same cycle after a good frame -> frame_err = 1, no frame_valid, buttons unchanged; next good frame clears frame_err.
REQ-039 Reset mid-frame: rst low during byte 3 -> all outputs at reset values; the subsequent full frame decodes correctly.
REQ-040 c_counter jumps from 4 to 10 -> no buffer write, no X propagation.
